// File: rtl/sar_adc.sv
// ----------------------------------------------------------------------------
// sar_adc -- behavioural successive-approximation ADC.
//
// Samples a real-valued analog input when start is seen in IDLE, then resolves
// one bit per clock, MSB first, against a real-valued reference ladder.
// The result is an unsigned N-bit code presented with a busy/done handshake.
// Inputs below 0 V resolve to 0 and inputs at or above Vref resolve to all
// ones; both outcomes fall out of the binary search itself.
//
// Optional feature macro: SAR_ADC_OVR_EN
//   When defined, port ovr is added. It flags a held sample outside [0, Vref)
//   and is registered together with D_out on the done edge.
// ----------------------------------------------------------------------------
module sar_adc #(
    parameter real Vref = 3.3,
    parameter int  N    = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  real          A_in,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] D_out
`ifdef SAR_ADC_OVR_EN
    ,
    output logic         ovr
`endif
);

    // Width of the bit-position counter; N is at least 2 so $clog2 is >= 1.
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    // Volts per code step.
    localparam real LSB_V = Vref / real'(32'd1 << N);

    typedef enum logic {
        IDLE    = 1'b0,
        CONVERT = 1'b1
    } state_t;

    state_t        state;
    real           sample_v;
    logic [N-1:0]  trial;
    logic [KW-1:0] k;

    logic [N-1:0]  test;
    logic          keep;
    logic [N-1:0]  next_trial;

    // One-hot mask selecting the bit currently being decided.
    function automatic logic [N-1:0] bit_mask(input logic [KW-1:0] pos);
        logic [N-1:0] one;
        one = {{(N-1){1'b0}}, 1'b1};
        return one << pos;
    endfunction

    // Analog level that a candidate code represents on the reference ladder.
    function automatic real threshold(input logic [N-1:0] code);
        return real'(code) * LSB_V;
    endfunction

    // A sample outside the convertible window [0, Vref).
    function automatic logic out_of_range(input real v);
        return (v < 0.0) || (v >= Vref);
    endfunction

    // Trial step: tentatively set bit k and keep it if the held sample reaches
    // the corresponding ladder level.
    always_comb begin
        test       = trial | bit_mask(k);
        keep       = (sample_v >= threshold(test));
        next_trial = keep ? test : trial;
    end

    // Conversion FSM: sample-and-hold in IDLE, one bit decision per clock in
    // CONVERT, result and handshake registered on the final decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            D_out    <= '0;
            sample_v <= 0.0;
            trial    <= '0;
            k        <= '0;
`ifdef SAR_ADC_OVR_EN
            ovr      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    // done is a single-cycle pulse; it drops on the edge after
                    // the result, even when a new start is taken on that edge.
                    done <= 1'b0;
                    if (start) begin
                        sample_v <= A_in;
                        trial    <= '0;
                        k        <= KW'(N - 1);
                        busy     <= 1'b1;
                        state    <= CONVERT;
                    end
                end
                CONVERT: begin
                    trial <= next_trial;
                    if (k == '0) begin
                        D_out <= next_trial;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
`ifdef SAR_ADC_OVR_EN
                        ovr   <= out_of_range(sample_v);
`endif
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
